// File: rtl/priority_encoder_8x3_if.sv
// ---------------------------------------------------------------------------
// priority_encoder_8x3_if
// Purpose : bundles the request-word handshake and the code-output handshake
//           of priority_encoder_8x3 into one bus.
// Signals :
//   in_valid   request word d is present          (source -> encoder)
//   in_ready   encoder can take a word (IDLE)      (encoder -> source)
//   d[7:0]     request word, bit i = index i       (source -> encoder)
//   code_valid code holds a valid index            (encoder -> consumer)
//   code_ready consumer takes code this cycle      (consumer -> encoder)
//   code[2:0]  current priority index              (encoder -> consumer)
//   last       final code of the current word      (encoder -> consumer)
//   zero       one-cycle pulse: accepted word was 0 (encoder -> consumer)
// Modports:
//   master - the surrounding system (request source plus code consumer)
//   slave  - the encoder itself
// ---------------------------------------------------------------------------
interface priority_encoder_8x3_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d;
  logic       code_valid;
  logic       code_ready;
  logic [2:0] code;
  logic       last;
  logic       zero;

  modport master (
    output in_valid,
    output d,
    output code_ready,
    input  in_ready,
    input  code_valid,
    input  code,
    input  last,
    input  zero
  );

  modport slave (
    input  in_valid,
    input  d,
    input  code_ready,
    output in_ready,
    output code_valid,
    output code,
    output last,
    output zero
  );
endinterface

// File: rtl/priority_encoder_8x3.sv
// ---------------------------------------------------------------------------
// priority_encoder_8x3
// Purpose : sequential 8-to-3 encoder. Takes an 8-bit request word and emits,
//           one per handshake, the 3-bit index of every set bit in priority
//           order. The final code of a word carries 'last'. An all-zero word
//           is not encoded; it produces a one-cycle 'zero' pulse instead.
// Params  :
//   LSB_FIRST  1: lowest set index first, 0: highest set index first
// Ports   :
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        priority_encoder_8x3_if.slave (see interface header)
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | in_ready=1, waiting for a request word; zero words handled here
// ST_EMIT | code_valid=1, draining set bits of r_pending one per handshake
// ---------------------------------------------------------------------------
module priority_encoder_8x3 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  priority_encoder_8x3_if.slave  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] r_pending;
  logic [7:0] w_pending_nxt;
  logic       r_zero;
  logic       w_zero_nxt;

  logic [2:0] w_code;
  logic       w_last;
  logic [7:0] w_code_onehot;
  logic       w_accept;
  logic       w_emit_fire;

  // -------------------------------------------------------------------------
  // Priority selection over the pending bits. The loop runs from the
  // lowest-priority end towards the highest so the last match wins.
  // An empty word yields index 0, which is what reset must show on 'code'.
  // -------------------------------------------------------------------------
  always_comb begin
    w_code = 3'd0;
    if (LSB_FIRST) begin
      for (int i = 7; i >= 0; i--) begin
        if (r_pending[i]) w_code = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (r_pending[i]) w_code = 3'(i);
      end
    end
  end

  // Exactly one bit left: clearing the lowest set bit leaves nothing.
  assign w_last        = (r_pending != 8'd0) &&
                         ((r_pending & (r_pending - 8'd1)) == 8'd0);
  assign w_code_onehot = 8'd1 << w_code;

  assign w_accept    = (r_state == ST_IDLE) && bus.in_valid;
  assign w_emit_fire = (r_state == ST_EMIT) && bus.code_ready;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pending <= 8'd0;
      r_zero    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_zero    <= w_zero_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_zero_nxt    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (bus.d != 8'd0) begin
            w_pending_nxt = bus.d;
            w_state_nxt   = ST_EMIT;
          end else begin
            // Zero word: flagged only, pending stays empty, stay ready.
            w_zero_nxt = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (w_emit_fire) begin
          w_pending_nxt = r_pending & ~w_code_onehot;
          if (w_last) w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_pending_nxt = 8'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic. code/last are gated by EMIT so that reset and IDLE read as
  // zero rather than leaking whatever the priority logic produces.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.in_ready   = 1'b0;
    bus.code_valid = 1'b0;
    bus.code       = 3'd0;
    bus.last       = 1'b0;
    bus.zero       = r_zero;
    unique case (r_state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
      end
      ST_EMIT: begin
        bus.code_valid = 1'b1;
        bus.code       = w_code;
        bus.last       = w_last;
      end
      default: begin
        bus.in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_priority_encoder_8x3.sv
module tb_priority_encoder_8x3;

  logic       clk;
  logic       rst_n;
  logic       tb_in_valid;
  logic [7:0] tb_d;
  logic       tb_code_ready;

  int total;
  int bad;

  priority_encoder_8x3_if if_l ();
  priority_encoder_8x3_if if_m ();

  assign if_l.in_valid   = tb_in_valid;
  assign if_l.d          = tb_d;
  assign if_l.code_ready = tb_code_ready;
  assign if_m.in_valid   = tb_in_valid;
  assign if_m.d          = tb_d;
  assign if_m.code_ready = tb_code_ready;

  priority_encoder_8x3 #(.LSB_FIRST(1'b1)) u_dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_l.slave)
  );

  priority_encoder_8x3 #(.LSB_FIRST(1'b0)) u_dut_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_m.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a word for one accepting edge; returns at the negedge after it.
  task automatic send(input logic [7:0] w);
    tb_in_valid = 1'b1;
    tb_d        = w;
    @(negedge clk);
    tb_in_valid = 1'b0;
    tb_d        = 8'h00;
  endtask

  function automatic logic [2:0] lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic [2:0] highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic int popcnt(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) if (v[i]) n++;
    return n;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] exp_l [4];
    logic [2:0] exp_m [4];
    logic [7:0] rem_l;
    logic [7:0] rem_m;
    int         pop;
    int         emitted;
    int         guard;

    total = 0;
    bad   = 0;
    exp_l = '{3'd0, 3'd2, 3'd5, 3'd7};
    exp_m = '{3'd7, 3'd5, 3'd2, 3'd0};

    rst_n         = 1'b0;
    tb_in_valid   = 1'b0;
    tb_d          = 8'h00;
    tb_code_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready",   8'(if_l.in_ready),   8'd1);
    chk("rst_code_valid", 8'(if_l.code_valid), 8'd0);
    chk("rst_zero",       8'(if_l.zero),       8'd0);
    chk("rst_last",       8'(if_l.last),       8'd0);
    chk("rst_code",       8'(if_l.code),       8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-hot 8'h20
    tb_code_ready = 1'b1;
    send(8'h20);
    chk("sh_valid",    8'(if_l.code_valid), 8'd1);
    chk("sh_code",     8'(if_l.code),       8'd5);
    chk("sh_code_msb", 8'(if_m.code),       8'd5);
    chk("sh_last",     8'(if_l.last),       8'd1);
    chk("sh_in_ready", 8'(if_l.in_ready),   8'd0);
    @(negedge clk);
    chk("sh_valid_off", 8'(if_l.code_valid), 8'd0);
    chk("sh_ready_on",  8'(if_l.in_ready),   8'd1);
    @(negedge clk);

    // Multi-hot 8'hA5 in both priority orders
    send(8'hA5);
    for (int i = 0; i < 4; i++) begin
      chk("a5_valid",    8'(if_l.code_valid), 8'd1);
      chk("a5_code_lsb", 8'(if_l.code),       8'(exp_l[i]));
      chk("a5_code_msb", 8'(if_m.code),       8'(exp_m[i]));
      chk("a5_last_lsb", 8'(if_l.last),       8'(i == 3));
      chk("a5_last_msb", 8'(if_m.last),       8'(i == 3));
      @(negedge clk);
    end
    chk("a5_done", 8'(if_l.in_ready), 8'd1);
    @(negedge clk);

    // Backpressure on 8'h81
    tb_code_ready = 1'b0;
    send(8'h81);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid",    8'(if_l.code_valid), 8'd1);
      chk("bp_code",     8'(if_l.code),       8'd0);
      chk("bp_code_msb", 8'(if_m.code),       8'd7);
      chk("bp_last",     8'(if_l.last),       8'd0);
      chk("bp_in_ready", 8'(if_l.in_ready),   8'd0);
      @(negedge clk);
    end
    tb_code_ready = 1'b1;
    chk("bp_rel_code", 8'(if_l.code),     8'd0);
    chk("bp_rel_last", 8'(if_l.last),     8'd0);
    chk("bp_rel_inr",  8'(if_l.in_ready), 8'd0);
    @(negedge clk);
    chk("bp_2nd_code", 8'(if_l.code),     8'd7);
    chk("bp_2nd_last", 8'(if_l.last),     8'd1);
    chk("bp_2nd_inr",  8'(if_l.in_ready), 8'd0);
    @(negedge clk);
    chk("bp_done", 8'(if_l.in_ready), 8'd1);

    // Back-to-back zero words
    tb_in_valid = 1'b1;
    tb_d        = 8'h00;
    @(negedge clk);
    chk("z1_zero",  8'(if_l.zero),       8'd1);
    chk("z1_valid", 8'(if_l.code_valid), 8'd0);
    chk("z1_inr",   8'(if_l.in_ready),   8'd1);
    @(negedge clk);
    tb_in_valid = 1'b0;
    chk("z2_zero",  8'(if_l.zero),       8'd1);
    chk("z2_valid", 8'(if_l.code_valid), 8'd0);
    chk("z2_inr",   8'(if_l.in_ready),   8'd1);
    @(negedge clk);
    chk("z_end", 8'(if_l.zero), 8'd0);

    // All 256 words, random consumer backpressure
    for (int v = 0; v < 256; v++) begin
      tb_code_ready = 1'b0;
      send(8'(v));
      if (v == 0) begin
        chk("ex_zero",  8'(if_l.zero),       8'd1);
        chk("ex_zvld",  8'(if_l.code_valid), 8'd0);
        @(negedge clk);
      end else begin
        rem_l   = 8'(v);
        rem_m   = 8'(v);
        pop     = popcnt(8'(v));
        emitted = 0;
        guard   = 0;
        while (emitted < pop && guard < 200) begin
          chk("ex_valid",    8'(if_l.code_valid), 8'd1);
          chk("ex_zero_off", 8'(if_l.zero),       8'd0);
          chk("ex_code_lsb", 8'(if_l.code),       8'(lowest(rem_l)));
          chk("ex_code_msb", 8'(if_m.code),       8'(highest(rem_m)));
          chk("ex_last_lsb", 8'(if_l.last),       8'(emitted == pop - 1));
          chk("ex_last_msb", 8'(if_m.last),       8'(emitted == pop - 1));
          tb_code_ready = 1'($urandom_range(0, 1));
          if (tb_code_ready) begin
            rem_l[lowest(rem_l)]  = 1'b0;
            rem_m[highest(rem_m)] = 1'b0;
            emitted++;
          end
          guard++;
          @(negedge clk);
        end
        chk("ex_guard",    8'(guard < 200),     8'd1);
        chk("ex_end_vld",  8'(if_l.code_valid), 8'd0);
        chk("ex_end_inr",  8'(if_l.in_ready),   8'd1);
      end
    end

    // Asynchronous reset in the middle of 8'hFF
    tb_code_ready = 1'b1;
    send(8'hFF);
    for (int i = 0; i < 3; i++) begin
      chk("rm_code", 8'(if_l.code), 8'(i));
      if (i < 2) @(negedge clk);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_async_vld",  8'(if_l.code_valid), 8'd0);
    chk("rm_async_inr",  8'(if_l.in_ready),   8'd1);
    chk("rm_async_code", 8'(if_l.code),       8'd0);
    chk("rm_async_last", 8'(if_l.last),       8'd0);
    tb_in_valid = 1'b1;
    tb_d        = 8'h40;
    @(negedge clk);
    @(negedge clk);
    chk("rm_hold_vld",  8'(if_l.code_valid), 8'd0);
    chk("rm_hold_zero", 8'(if_l.zero),       8'd0);
    tb_in_valid = 1'b0;
    tb_d        = 8'h00;
    rst_n       = 1'b1;
    @(negedge clk);
    chk("rm_rel_inr", 8'(if_l.in_ready),   8'd1);
    chk("rm_rel_vld", 8'(if_l.code_valid), 8'd0);
    send(8'h02);
    chk("rm_next_vld",  8'(if_l.code_valid), 8'd1);
    chk("rm_next_code", 8'(if_l.code),       8'd1);
    chk("rm_next_last", 8'(if_l.last),       8'd1);
    @(negedge clk);
    chk("rm_next_done", 8'(if_l.in_ready), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
